// File: rtl/pla_pipe_eval.sv
// pla_pipe_eval: run-time loadable two-level AND-OR plane evaluator with serial configuration load.
// Latency: an input accepted in cycle n shows out_valid in cycle n+2; one vector per cycle.
// Backpressure: out_ready low holds stage 2, then stage 1; in_ready drops once both stages are full.
module pla_pipe_eval #(
   parameter int NUM_IN    = 10,
   parameter int NUM_OUT   = 7,
   parameter int NUM_TERMS = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic               cfg_bit_valid,
   input  logic               cfg_bit,
   output logic               cfg_done,
   output logic               configured,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUM_IN-1:0]  pi,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] po
);

   // Layout of the configuration vector: AND plane, then OR plane, then output polarity.
   localparam int A_BASE  = 2 * NUM_IN * NUM_TERMS;
   localparam int B_BASE  = A_BASE + NUM_OUT * NUM_TERMS;
   localparam int CFG_LEN = B_BASE + NUM_OUT;
   localparam int CW      = $clog2(CFG_LEN);

   typedef enum logic [1:0] {
      ST_UNCFG,
      ST_LOAD,
      ST_RUN
   } state_t;

   state_t               state_q;
   logic [CFG_LEN-1:0]   cfg_q;
   logic [CW-1:0]        cnt_q;
   logic                 cfg_done_q;
   logic                 configured_q;

   logic [NUM_TERMS-1:0] term_d;
   logic [NUM_TERMS-1:0] term_q;
   logic                 v1_q;
   logic [NUM_OUT-1:0]   po_d;
   logic [NUM_OUT-1:0]   po_q;
   logic                 out_valid_q;

   logic                 stage2_adv;
   logic                 in_rdy;

   // Stage 2 can take a new result when it is empty or its current result leaves this cycle.
   assign stage2_adv = ~out_valid_q | out_ready;
   // Stage 1 accepts when empty or when it can drain into stage 2.
   assign in_rdy     = (state_q == ST_RUN) & (~v1_q | stage2_adv);

   assign in_ready   = in_rdy;
   assign out_valid  = out_valid_q;
   assign po         = po_q;
   assign cfg_done   = cfg_done_q;
   assign configured = configured_q;

   // Configuration FSM: serial load of the plane bits; a restart always wins over a data bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_UNCFG;
         cfg_q        <= '0;
         cnt_q        <= '0;
         cfg_done_q   <= 1'b0;
         configured_q <= 1'b0;
      end else begin
         cfg_done_q <= 1'b0;
         if (cfg_start) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            configured_q <= 1'b0;
         end else if (state_q == ST_LOAD && cfg_bit_valid) begin
            cfg_q[cnt_q] <= cfg_bit;
            if (cnt_q == CW'(CFG_LEN - 1)) begin
               state_q      <= ST_RUN;
               configured_q <= 1'b1;
               cfg_done_q   <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   // AND plane: a term drops when a required-one input is 0 or a required-zero input is 1.
   always_comb begin
      term_d = '1;
      for (int t = 0; t < NUM_TERMS; t++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (cfg_q[2*NUM_IN*t + 2*i] && !pi[i]) begin
               term_d[t] = 1'b0;
            end
            if (cfg_q[2*NUM_IN*t + 2*i + 1] && pi[i]) begin
               term_d[t] = 1'b0;
            end
         end
      end
   end

   // OR plane and output polarity applied to the registered term bits.
   always_comb begin
      po_d = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         for (int t = 0; t < NUM_TERMS; t++) begin
            po_d[o] = po_d[o] | (cfg_q[A_BASE + o*NUM_TERMS + t] & term_q[t]);
         end
         po_d[o] = po_d[o] ^ cfg_q[B_BASE + o];
      end
   end

   // Stage 1: capture the term bits of an accepted vector; a restart drops anything in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1_q   <= 1'b0;
         term_q <= '0;
      end else if (cfg_start) begin
         v1_q <= 1'b0;
      end else if (in_rdy) begin
         v1_q <= in_valid;
         if (in_valid) begin
            term_q <= term_d;
         end
      end
   end

   // Stage 2: register the result; held unchanged while downstream stalls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         po_q        <= '0;
      end else if (cfg_start) begin
         out_valid_q <= 1'b0;
      end else if (stage2_adv) begin
         out_valid_q <= v1_q;
         if (v1_q) begin
            po_q <= po_d;
         end
      end
   end

endmodule

// File: tb/tb_pla_pipe_eval.sv
// tb_pla_pipe_eval: scoreboard bench for pla_pipe_eval.
// Drives configuration loads and vector streams; results are checked against a bench-side plane model.
// Output stalls are generated by the bench through out_ready.
module tb_pla_pipe_eval;

   localparam int NI = 10;
   localparam int NO = 7;
   localparam int NT = 16;
   localparam int A  = 2 * NI * NT;
   localparam int B  = A + NO * NT;
   localparam int L  = B + NO;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_bit_valid = 1'b0;
   logic          cfg_bit = 1'b0;
   logic          cfg_done;
   logic          configured;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NI-1:0] pi = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [NO-1:0] po;

   int vectors = 0;
   int miscompares = 0;
   logic [L-1:0] cur_cfg = '0;

   pla_pipe_eval #(
      .NUM_IN   (NI),
      .NUM_OUT  (NO),
      .NUM_TERMS(NT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .cfg_start    (cfg_start),
      .cfg_bit_valid(cfg_bit_valid),
      .cfg_bit      (cfg_bit),
      .cfg_done     (cfg_done),
      .configured   (configured),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .pi           (pi),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .po           (po)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: each term is a pair of masks that must match pi.
   function automatic logic [NO-1:0] model(input logic [L-1:0] c, input logic [NI-1:0] x);
      logic [NT-1:0] tm;
      logic [NO-1:0] r;
      for (int t = 0; t < NT; t++) begin
         logic [NI-1:0] m1;
         logic [NI-1:0] m0;
         for (int i = 0; i < NI; i++) begin
            m1[i] = c[2*NI*t + 2*i];
            m0[i] = c[2*NI*t + 2*i + 1];
         end
         tm[t] = ((x & m1) == m1) && ((~x & m0) == m0);
      end
      for (int o = 0; o < NO; o++) begin
         logic [NT-1:0] row;
         for (int t = 0; t < NT; t++) row[t] = c[A + o*NT + t];
         r[o] = (|(tm & row)) ^ c[B + o];
      end
      return r;
   endfunction

   function automatic logic [L-1:0] rand_cfg();
      logic [L-1:0] c;
      c = '0;
      for (int t = 0; t < NT; t++) begin
         for (int j = 0; j < 3; j++) begin
            int i;
            i = int'($urandom_range(0, NI - 1));
            if ($urandom_range(0, 1) == 1) c[2*NI*t + 2*i] = 1'b1;
            else c[2*NI*t + 2*i + 1] = 1'b1;
         end
      end
      for (int b = A; b < L; b++) c[b] = 1'($urandom_range(0, 1));
      return c;
   endfunction

   // term0 = ~pi7 & ~pi8 & ~pi9 on po2; terms 1..15 forced to 0.
   function automatic logic [L-1:0] cover_cfg(input logic pol2);
      logic [L-1:0] c;
      c = '0;
      c[2*7 + 1] = 1'b1;
      c[2*8 + 1] = 1'b1;
      c[2*9 + 1] = 1'b1;
      for (int t = 1; t < NT; t++) begin
         c[2*NI*t]     = 1'b1;
         c[2*NI*t + 1] = 1'b1;
      end
      c[A + 2*NT + 0] = 1'b1;
      c[B + 2]        = pol2;
      return c;
   endfunction

   task automatic load_cfg(input logic [L-1:0] v, input string name);
      int early;
      int busy;
      early = 0;
      busy  = 0;
      @(negedge clock);
      in_valid      = 1'b0;
      cfg_start     = 1'b1;
      cfg_bit_valid = 1'b1;
      cfg_bit       = ~v[0];
      @(negedge clock);
      cfg_start = 1'b0;
      for (int k = 0; k < L; k++) begin
         cfg_bit_valid = 1'b1;
         cfg_bit       = v[k];
         @(negedge clock);
         if (k != L - 1) begin
            if (cfg_done === 1'b1) early++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || configured !== 1'b0) busy++;
         end
      end
      cfg_bit_valid = 1'b0;
      vectors++;
      if (early != 0) begin
         miscompares++;
         $display("FAIL %s early_done: got %0d early pulses, expected 0", name, early);
      end
      vectors++;
      if (busy != 0) begin
         miscompares++;
         $display("FAIL %s load_idle: got %0d cycles with in_ready/out_valid/configured set, expected 0", name, busy);
      end
      vectors++;
      if (cfg_done !== 1'b1 || configured !== 1'b1) begin
         miscompares++;
         $display("FAIL %s done_pulse: got cfg_done=%b configured=%b, expected 1 1", name, cfg_done, configured);
      end
      @(negedge clock);
      vectors++;
      if (cfg_done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done_width: got cfg_done=%b, expected 0", name, cfg_done);
      end
      cur_cfg = v;
   endtask

   task automatic apply_one(input logic [NI-1:0] x, input logic [NO-1:0] exp, input string name);
      int n;
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      pi        = x;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      @(negedge clock);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      vectors++;
      if (out_valid !== 1'b1 || po !== exp) begin
         miscompares++;
         $display("FAIL %s: got po=%b out_valid=%b, expected po=%b out_valid=1", name, po, out_valid, exp);
      end
   endtask

   task automatic run_stream(input int n, input int stall_at, input int stall_len, input string name);
      logic [NO-1:0] exp_q[$];
      logic [NO-1:0] exp;
      logic [NI-1:0] cur;
      logic [NO-1:0] prev_po;
      logic          prev_stall;
      logic          exp_rdy;
      int sent, got, cyc, first_acc, first_out, last_out;
      sent = 0; got = 0; cyc = 0;
      first_acc = -1; first_out = -1; last_out = -1;
      prev_stall = 1'b0;
      prev_po = '0;
      cur = NI'($urandom);
      while ((sent < n || exp_q.size() != 0) && cyc < 300) begin
         @(negedge clock);
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         in_valid  = (sent < n);
         pi        = cur;
         #1;
         if (prev_stall) begin
            vectors++;
            if (out_valid !== 1'b1 || po !== prev_po) begin
               miscompares++;
               $display("FAIL %s hold: got po=%b out_valid=%b, expected po=%b out_valid=1", name, po, out_valid, prev_po);
            end
         end
         exp_rdy = (exp_q.size() < 2) || out_ready;
         vectors++;
         if (in_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL %s in_ready cyc %0d: got %b, expected %b", name, cyc, in_ready, exp_rdy);
         end
         if (out_valid === 1'b1 && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL %s spurious: got po=%b, expected no output", name, po);
            end else begin
               exp = exp_q.pop_front();
               if (po !== exp) begin
                  miscompares++;
                  $display("FAIL %s result %0d: got po=%b, expected %b", name, got, po, exp);
               end
            end
            got++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(model(cur_cfg, cur));
            sent++;
            if (first_acc < 0) first_acc = cyc;
            cur = NI'($urandom);
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_po    = po;
         cyc++;
      end
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      vectors++;
      if (sent != n || exp_q.size() != 0 || got != n) begin
         miscompares++;
         $display("FAIL %s count: got sent=%0d received=%0d pending=%0d, expected %0d %0d 0", name, sent, got, exp_q.size(), n, n);
      end
      if (stall_len == 0) begin
         vectors++;
         if (first_out - first_acc != 2) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected 2", name, first_out - first_acc);
         end
         vectors++;
         if (last_out - first_out != n - 1) begin
            miscompares++;
            $display("FAIL %s throughput: got span %0d cycles, expected %0d", name, last_out - first_out, n - 1);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || po !== '0 || configured !== 1'b0 || cfg_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got in_ready=%b out_valid=%b po=%b configured=%b cfg_done=%b, expected all 0",
                  in_ready, out_valid, po, configured, cfg_done);
      end
   endtask

   task automatic test_first_load();
      load_cfg(rand_cfg(), "first_load");
      run_stream(4, 1000, 0, "first_stream");
   endtask

   task automatic test_cover();
      load_cfg(cover_cfg(1'b0), "cover_load");
      apply_one(10'h000, 7'b0000100, "cover_000");
      apply_one(10'h080, 7'b0000000, "cover_080");
      apply_one(10'h07F, 7'b0000100, "cover_07f");
      apply_one(10'h100, 7'b0000000, "cover_100");
   endtask

   task automatic test_polarity();
      load_cfg(cover_cfg(1'b1), "pol_load");
      apply_one(10'h000, 7'b0000000, "pol_000");
      apply_one(10'h200, 7'b0000100, "pol_200");
   endtask

   task automatic test_ignore_cfg();
      @(negedge clock);
      for (int k = 0; k < 30; k++) begin
         cfg_bit_valid = 1'b1;
         cfg_bit       = 1'b1;
         @(negedge clock);
      end
      cfg_bit_valid = 1'b0;
      vectors++;
      if (configured !== 1'b1 || cfg_done !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_state: got configured=%b cfg_done=%b, expected 1 0", configured, cfg_done);
      end
      apply_one(10'h000, 7'b0000000, "ignore_000");
      apply_one(10'h200, 7'b0000100, "ignore_200");
   endtask

   task automatic test_back_to_back();
      load_cfg(rand_cfg(), "b2b_load");
      run_stream(8, 1000, 0, "b2b");
      run_stream(12, 4, 3, "b2b_stall");
   endtask

   task automatic test_flush();
      @(negedge clock);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      pi        = NI'($urandom);
      @(negedge clock);
      pi = NI'($urandom);
      @(negedge clock);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_fill: got out_valid=%b, expected 1", out_valid);
      end
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
      out_ready = 1'b1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || configured !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_drop: got out_valid=%b in_ready=%b configured=%b, expected 0 0 0", out_valid, in_ready, configured);
      end
      load_cfg(rand_cfg(), "flush_reload");
      run_stream(5, 1000, 0, "flush_stream");
   endtask

   task automatic test_reset_mid_load();
      logic [L-1:0] v;
      v = rand_cfg();
      @(negedge clock);
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         cfg_bit_valid = 1'b1;
         cfg_bit       = v[k];
         @(negedge clock);
      end
      cfg_bit_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (configured !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || cfg_done !== 1'b0 || po !== '0) begin
         miscompares++;
         $display("FAIL midload_reset: got configured=%b in_ready=%b out_valid=%b cfg_done=%b po=%b, expected all 0",
                  configured, in_ready, out_valid, cfg_done, po);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      load_cfg(rand_cfg(), "midload_reload");
      run_stream(6, 1000, 0, "midload_stream");
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_cover();
      test_polarity();
      test_ignore_cfg();
      test_back_to_back();
      test_flush();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pla_pipe_eval.md
Name: pla_pipe_eval

Overview:
- Run-time programmable two-level AND-OR (PLA) evaluator with registered, two-stage pipelined evaluation and valid/ready flow control on input and output.
- Successor to our fixed combinational control decoders. Input count, output count and product-term count are parameters.
- The plane contents are loaded serially at run time, so one instance can implement any cover that fits its term budget.
- Sits between a source of control vectors and downstream logic in benchmark-style control paths.

Parameters:
- NUM_IN, 10, number of primary inputs (pi bus width), 1..32
- NUM_OUT, 7, number of primary outputs (po bus width), 1..32
- NUM_TERMS, 16, product terms in the AND plane, 1..64

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_start  in  1  begin/restart configuration load
- cfg_bit_valid  in  1  cfg_bit is valid this cycle
- cfg_bit  in  1  serial configuration bit
- cfg_done  out  1  one-cycle pulse when the load completes
- configured  out  1  high while in RUN
- in_valid  in  1  pi carries a vector
- in_ready  out  1  block accepts pi this cycle
- pi  in  NUM_IN  input vector
- out_valid  out  1  po holds a result
- out_ready  in  1  downstream accepts po
- po  out  NUM_OUT  result vector

Behaviour:
- Config vector CFG has length L = NUM_TERMS*2*NUM_IN + NUM_OUT*NUM_TERMS + NUM_OUT. With the defaults L = 439.
- The k-th accepted cfg_bit is written to CFG[k].
- AND plane, term t, input i:
  - need1 = CFG[2*NUM_IN*t + 2*i], need0 = CFG[2*NUM_IN*t + 2*i + 1].
  - Term t = AND over i of (~need1 | pi[i]) & (~need0 | ~pi[i]).
  - All-zero masks give constant 1. need1 and need0 both set on one input gives constant 0.
- OR plane: with A = 2*NUM_IN*NUM_TERMS, output o = OR over t of (CFG[A + o*NUM_TERMS + t] & term t).
- Polarity: with B = A + NUM_OUT*NUM_TERMS, po[o] = OR-result XOR CFG[B+o].
- States:
  - UNCFG: after reset. in_ready=0, configured=0.
  - LOAD: counts accepted bits 0..L-1. in_ready=0.
  - RUN: configured=1. Evaluation enabled.
- Transitions:
  - Any state, cfg_start=1 → LOAD with count=0. In RUN, both pipeline valid flags clear and in-flight results are dropped.
  - cfg_start and cfg_bit_valid in the same cycle: cfg_start wins and that bit is discarded.
  - LOAD, cfg_bit_valid with count=L-1 → RUN. cfg_done=1 for exactly the next cycle.
- cfg_bit_valid outside LOAD is ignored; CFG and count are unchanged.
- Pipeline:
  - Stage 1 registers the NUM_TERMS term bits plus valid v1.
  - Stage 2 registers po plus out_valid.
  - Latency: input accepted at edge n → po valid after edge n+2 (out_valid visible in cycle n+2) when unstalled.
  - Throughput: 1 vector per cycle.
- Handshake:
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - in_ready = RUN & (~v1 | ~out_valid | out_ready). Full-throughput stall propagation, no bubble while out_ready=1.
  - Stage 2 holds po and out_valid stable while out_valid=1 and out_ready=0.
  - in_valid does not depend on in_ready, and out_valid does not depend on out_ready (no combinational loops).
- Reset, asynchronous, at any time including mid-LOAD or mid-stream:
  - state=UNCFG, CFG=0, count=0, v1=0.
  - out_valid=0, po=0, cfg_done=0, configured=0, in_ready=0.
- CFG is never observed by evaluation while in LOAD, because the pipeline is flushed and in_ready=0, so no shadow copy is required.

Test Plan:
- Reset, then 5 idle cycles → in_ready=0, out_valid=0, po=0, configured=0. Drive 439 cfg bits → cfg_done pulses once on the cycle after the last bit; configured=1.
- Configure term0 = ~pi7&~pi8&~pi9 mapped to po2, all other terms constant 0, polarity 0:
  - pi=10'h000 → po=7'b0000100.
  - pi=10'h080 → po=0.
- Same cover with polarity bit 2 set → pi=10'h000 gives po=0 and pi=10'h200 gives po[2]=1.
- Back-to-back stream of 8 vectors with out_ready=1 → 8 results on consecutive cycles, first result 2 cycles after first accept. Hold out_ready=0 for 3 cycles mid-stream → po stable, in_ready=0 once both stages are full, no loss or duplication.
- cfg_start while 2 results are in flight → out_valid drops the next cycle, the dropped results never appear, in_ready=0 until reload completes.
- Assert reset during LOAD at bit 200 → UNCFG. A fresh full load then behaves as a first load; partial bits are not retained (CFG=0 before reload).
